// File: rtl/hazard_sched_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_sched_pkg;

    // Load-type encoding of "not a load", shared with the datapath decode.
    localparam logic [2:0] DMRD_NOP = 3'b000;

    typedef enum logic {
        HZ_RUN      = 1'b0,
        HZ_MDU_BUSY = 1'b1
    } hz_state_t;

    function automatic logic reg_match(input logic use_r, input logic [4:0] src,
                                       input logic [4:0] dst);
        return use_r && (src == dst);
    endfunction

endpackage

// File: rtl/hazard_sched_if.sv
// Pipeline-to-hazard-controller signal bundle; slave is the controller, master the pipeline.
interface hazard_sched_if #(
    parameter int PERF_W = 32,
    parameter int CNT_W  = 6
);
    logic [2:0]  IDEX_DMRd;
    logic [4:0]  IDEX_rd;
    logic [4:0]  IFID_rs;
    logic [4:0]  IFID_rt;
    logic        IFID_use_rs;
    logic        IFID_use_rt;
    logic        IFID_mdu;
    logic        IFID_hilo;
    logic        EX_br_taken;
    logic        PC_Wr;
    logic        IFID_Wr;
    logic        IFID_flush;
    logic        IDEX_flush;
    logic        mdu_start;
    logic        mdu_busy;
    logic        mdu_done;
    logic [PERF_W-1:0] stall_cnt;
    hazard_sched_pkg::hz_state_t dbg_state;
    logic [CNT_W-1:0]  dbg_cnt;

    modport master (
        output IDEX_DMRd, IDEX_rd, IFID_rs, IFID_rt, IFID_use_rs, IFID_use_rt,
               IFID_mdu, IFID_hilo, EX_br_taken,
        input  PC_Wr, IFID_Wr, IFID_flush, IDEX_flush, mdu_start, mdu_busy,
               mdu_done, stall_cnt, dbg_state, dbg_cnt
    );

    modport slave (
        input  IDEX_DMRd, IDEX_rd, IFID_rs, IFID_rt, IFID_use_rs, IFID_use_rt,
               IFID_mdu, IFID_hilo, EX_br_taken,
        output PC_Wr, IFID_Wr, IFID_flush, IDEX_flush, mdu_start, mdu_busy,
               mdu_done, stall_cnt, dbg_state, dbg_cnt
    );

endinterface

// File: rtl/hazard_sched_mdu_timer.sv
// Loadable MDU countdown: load sets MDU_LAT-1, done pulses while the count reads 1.
module hazard_sched_mdu_timer #(
    parameter int MDU_LAT = 32,
    parameter int CNT_W   = 6
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    output logic [CNT_W-1:0] cnt,
    output logic             done
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_W'(MDU_LAT - 1);
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign done = (cnt == CNT_W'(1));

endmodule

// File: rtl/hazard_sched.sv
// Hazard controller: load-use stalls, taken-branch flushes and MDU/HI-LO interlock.
// Optional stall performance counter enabled by HAZARD_PERF_CNT_EN.
module hazard_sched
    import hazard_sched_pkg::*;
#(
    parameter int MDU_LAT = 32,
    parameter int CNT_W   = 6,
    parameter int PERF_W  = 32
) (
    input  logic          clk,
    input  logic          rstn,
    hazard_sched_if.slave hz
);

    hz_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             done;
    logic             lu_haz, mdu_haz;
    logic             pc_wr, ifid_wr, ifid_flush, idex_flush, start;

    // MDU strobes: mdu_start is a single-cycle launch with no back-pressure;
    // mdu_done is a single-cycle pulse on the last busy cycle, and the unit is
    // free again (state RUN) on the following edge.
    hazard_sched_mdu_timer #(
        .MDU_LAT(MDU_LAT),
        .CNT_W  (CNT_W)
    ) u_timer (
        .clk (clk),
        .rstn(rstn),
        .load(start),
        .cnt (cnt),
        .done(done)
    );

    assign lu_haz = (hz.IDEX_DMRd != DMRD_NOP) && (hz.IDEX_rd != 5'd0) &&
                    (reg_match(hz.IFID_use_rs, hz.IFID_rs, hz.IDEX_rd) ||
                     reg_match(hz.IFID_use_rt, hz.IFID_rt, hz.IDEX_rd));
    assign mdu_haz = (state == HZ_MDU_BUSY) && (hz.IFID_hilo || hz.IFID_mdu);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= HZ_RUN;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        pc_wr      = 1'b1;
        ifid_wr    = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        start      = 1'b0;
        if (state == HZ_MDU_BUSY && done) state_nxt = HZ_RUN;
        // A taken branch never touches the MDU sequencing; only issue is blocked.
        if (hz.EX_br_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (lu_haz || mdu_haz) begin
            pc_wr      = 1'b0;
            ifid_wr    = 1'b0;
            idex_flush = 1'b1;
        end else if (state == HZ_RUN && hz.IFID_mdu) begin
            start     = 1'b1;
            state_nxt = HZ_MDU_BUSY;
        end
    end

    assign hz.PC_Wr      = pc_wr;
    assign hz.IFID_Wr    = ifid_wr;
    assign hz.IFID_flush = ifid_flush;
    assign hz.IDEX_flush = idex_flush;
    assign hz.mdu_start  = start;
    assign hz.mdu_busy   = (state == HZ_MDU_BUSY);
    assign hz.mdu_done   = done;
    assign hz.dbg_state  = state;
    assign hz.dbg_cnt    = cnt;

`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_W-1:0] stall_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)       stall_q <= '0;
        else if (!pc_wr) stall_q <= stall_q + PERF_W'(1);
    end

    assign hz.stall_cnt = stall_q;
`else
    assign hz.stall_cnt = {PERF_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_sched.sv
// Directed scoreboard bench for hazard_sched (MDU_LAT=4); follows HAZARD_PERF_CNT_EN.
module tb_hazard_sched;
    import hazard_sched_pkg::*;

    localparam int MDU_LAT = 4;
    localparam int CNT_W   = 6;
    localparam int PERF_W  = 32;
    localparam int W       = 7 + PERF_W;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    // {PC_Wr, IFID_Wr, IFID_flush, IDEX_flush, mdu_start, mdu_busy, mdu_done}
    localparam logic [6:0] N   = 7'b1100000;
    localparam logic [6:0] S   = 7'b0001000;
    localparam logic [6:0] SB  = 7'b0001010;
    localparam logic [6:0] SD  = 7'b0001011;
    localparam logic [6:0] ST  = 7'b1100100;
    localparam logic [6:0] BR  = 7'b1111000;
    localparam logic [6:0] BRB = 7'b1111010;
    localparam logic [6:0] B   = 7'b1100010;
    localparam logic [6:0] D   = 7'b1100011;
    localparam logic [2:0] LW  = 3'b010;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic drv_done = 1'b0;
    int   checks = 0;
    int   failures = 0;
    logic [PERF_W-1:0] sc_model = '0;
    logic [W-1:0] exp_q[$];
    string        name_q[$];

    hazard_sched_if #(.PERF_W(PERF_W), .CNT_W(CNT_W)) bus ();

    hazard_sched #(
        .MDU_LAT(MDU_LAT),
        .CNT_W  (CNT_W),
        .PERF_W (PERF_W)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .hz  (bus)
    );

    // clock / reset
    always #5 clk = ~clk;

    // driver: one call per cycle, inputs applied just after the active edge
    task automatic step(input string nm, input logic [2:0] dmrd, input logic [4:0] rd,
                        input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                        input logic urt, input logic mdu, input logic hilo, input logic br,
                        input logic [6:0] exp, input logic rst_low);
        @(posedge clk);
        #1;
        bus.IDEX_DMRd   = dmrd;
        bus.IDEX_rd     = rd;
        bus.IFID_rs     = rs;
        bus.IFID_rt     = rt;
        bus.IFID_use_rs = urs;
        bus.IFID_use_rt = urt;
        bus.IFID_mdu    = mdu;
        bus.IFID_hilo   = hilo;
        bus.EX_br_taken = br;
        if (rst_low) begin
            rstn     = 1'b0;
            sc_model = '0;
        end
        exp_q.push_back({exp, (PERF_ON ? sc_model : {PERF_W{1'b0}})});
        name_q.push_back(nm);
        if (!exp[6]) sc_model = sc_model + PERF_W'(1);
        if (rst_low) begin
            @(negedge clk);
            #1;
            rstn = 1'b1;
        end
    endtask

    task automatic idle(input string nm, input logic [6:0] exp);
        step(nm, DMRD_NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp, 1'b0);
    endtask

    initial begin : stimulus
        step("reset", DMRD_NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, N, 1'b1);
        // load-use on rs and rt, then non-hazard variants
        step("lu_rs",      LW, 5'd8, 5'd8, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S, 1'b0);
        idle("lu_rs_rel", N);
        step("lu_rt",      LW, 5'd9, 5'd2, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, S, 1'b0);
        step("rt_unused",  LW, 5'd9, 5'd2, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, N, 1'b0);
        step("load_r0",    LW, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, N, 1'b0);
        step("no_load",    DMRD_NOP, 5'd8, 5'd8, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, N, 1'b0);
        // MDU issue, mfhi interlock
        step("mdu_start",  DMRD_NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ST, 1'b0);
        step("mfhi_b3",    DMRD_NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, SB, 1'b0);
        step("mfhi_b2",    DMRD_NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, SB, 1'b0);
        step("mfhi_done",  DMRD_NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, SD, 1'b0);
        step("mfhi_rel",   DMRD_NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, N, 1'b0);
        // back-to-back MDU ops, independent flow during busy
        step("mdu2_start", DMRD_NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ST, 1'b0);
        idle("indep_busy", B);
        step("mdu_b2",     DMRD_NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, SB, 1'b0);
        step("mdu_b1",     DMRD_NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, SD, 1'b0);
        step("mdu3_start", DMRD_NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ST, 1'b0);
        // branch during busy over an mfhi hazard; done stays on schedule
        step("br_busy",    DMRD_NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, BRB, 1'b0);
        idle("br_busy2", B);
        idle("br_done", D);
        idle("br_after", N);
        // branch over load-use, branch suppresses mdu_start
        step("br_lu",      LW, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, BR, 1'b0);
        step("br_mdu",     DMRD_NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, BR, 1'b0);
        idle("br_mdu_nob", N);
        // load-use with MDU op in ID: stall first, then issue
        step("lu_mdu",     LW, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, S, 1'b0);
        step("lu_mdu_iss", DMRD_NOP, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ST, 1'b0);
        idle("abort_b3", B);
        idle("abort_b2", B);
        // async reset mid-operation
        step("abort_rst",  DMRD_NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, N, 1'b1);
        idle("post_rst1", N);
        idle("post_rst2", N);
        idle("post_rst3", N);
        // counter survives after reset: one more stall
        step("lu_post",    LW, 5'd4, 5'd0, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, S, 1'b0);
        idle("final", N);
        drv_done = 1'b1;
    end

    // monitor / scoreboard; also owns the final report
    initial begin : monitor
        logic [W-1:0] exp_v;
        logic [W-1:0] got;
        string        nm;
        int           cyc;
        cyc = 0;
        while (!(drv_done && exp_q.size() == 0) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                nm    = name_q.pop_front();
                got   = {bus.PC_Wr, bus.IFID_Wr, bus.IFID_flush, bus.IDEX_flush,
                         bus.mdu_start, bus.mdu_busy, bus.mdu_done, bus.stall_cnt};
                checks++;
                if (got !== exp_v) begin
                    failures++;
                    $display("FAIL %s: got ctrl=%b cnt=%0d required ctrl=%b cnt=%0d (state=%0d timer=%0d)",
                             nm, got[W-1:PERF_W], got[PERF_W-1:0], exp_v[W-1:PERF_W],
                             exp_v[PERF_W-1:0], bus.dbg_state, bus.dbg_cnt);
                end
            end
        end
        if (exp_q.size() != 0 || !drv_done) begin
            checks++;
            failures++;
            $display("FAIL drain: pending=%0d required pending=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_sched.md
Name: hazard_sched

Overview:
- Pipeline hazard controller for the 5-stage MIPS core. It sits beside the forwarding unit.
- Handles the hazards forwarding cannot cover:
  - load-use stalls;
  - taken-branch flushes;
  - sequencing of the fixed-latency multiply/divide unit (MDU), including HI/LO interlock.
- Drives the PC, IF/ID and ID/EX write-enable and flush controls, and the MDU start strobe.

Parameters:
- MDU_LAT, 32, MDU execution latency in cycles (minimum 2).
- CNT_W, 6, width of the MDU countdown counter; must hold MDU_LAT-1.
- PERF_W, 32, width of the stall performance counter (optional feature only).

Ports:
- clk  in  1  core clock
- rstn  in  1  reset, asynchronous, active-low
- IDEX_DMRd  in  3  load type of the instruction in EX; `DMRd_NOP means not a load
- IDEX_rd  in  5  destination register of the instruction in EX
- IFID_rs  in  5  rs of the instruction in ID
- IFID_rt  in  5  rt of the instruction in ID
- IFID_use_rs  in  1  ID instruction reads rs
- IFID_use_rt  in  1  ID instruction reads rt
- IFID_mdu  in  1  ID instruction is mult/multu/div/divu
- IFID_hilo  in  1  ID instruction reads HI/LO (mfhi/mflo)
- EX_br_taken  in  1  branch/jump in EX resolved taken
- PC_Wr  out  1  PC write enable
- IFID_Wr  out  1  IF/ID write enable
- IFID_flush  out  1  clear IF/ID to nop
- IDEX_flush  out  1  insert bubble into ID/EX
- mdu_start  out  1  one-cycle MDU launch strobe
- mdu_busy  out  1  MDU operation in flight
- mdu_done  out  1  one-cycle pulse on the final MDU cycle
- stall_cnt  out  PERF_W  stall cycle count (optional feature only)

Behaviour:
- Clock and reset
  - Single clock, posedge.
  - Reset is asynchronous and active-low on rstn.
- Reset values
  - state=RUN, cnt=0.
  - PC_Wr=1, IFID_Wr=1.
  - IFID_flush=0, IDEX_flush=0.
  - mdu_start=0, mdu_busy=0, mdu_done=0, stall_cnt=0.
- Output timing
  - Outputs are combinational from the registered state plus the current inputs (Mealy).
  - mdu_busy is a direct decode of state.
- States: RUN, MDU_BUSY.
- lu_haz (load-use hazard) is true when all hold:
  - IDEX_DMRd != `DMRd_NOP;
  - IDEX_rd != 0;
  - (IFID_use_rs && IDEX_rd==IFID_rs) || (IFID_use_rt && IDEX_rd==IFID_rt).
- mdu_haz (MDU hazard) is true when state==MDU_BUSY && (IFID_hilo || IFID_mdu).
- Priority, evaluated every cycle:
  1. EX_br_taken:
     - IFID_flush=1, IDEX_flush=1, PC_Wr=1, IFID_Wr=1.
     - mdu_start is suppressed.
     - The state and counter are unaffected, so an in-flight MDU op continues.
  2. lu_haz or mdu_haz:
     - PC_Wr=0, IFID_Wr=0, IDEX_flush=1, IFID_flush=0.
     - A load-use stall lasts exactly 1 cycle, because the load advances to MEM.
  3. Otherwise, in RUN with IFID_mdu=1:
     - mdu_start=1.
     - Next cycle: state=MDU_BUSY, cnt=MDU_LAT-1.
  4. Otherwise: normal flow (enables 1, flushes 0).
- MDU_BUSY
  - cnt decrements by 1 each cycle.
  - Independent instructions flow without stalling.
  - When cnt==1: mdu_done=1 this cycle; next state is RUN with cnt=0.
  - A stalled mfhi/mflo or MDU op is released on the cycle after mdu_done.
  - Total busy span is MDU_LAT-1 cycles after the mdu_start cycle.
- Simultaneous events
  - Branch and hazard together: branch wins, with no stall. The hazarding ID instruction is wrong-path.
  - lu_haz together with IFID_mdu in RUN: stall, no mdu_start. The MDU op issues once the hazard clears.
- Reset mid-operation
  - Asserting rstn low in MDU_BUSY aborts immediately: state=RUN, cnt=0, mdu_busy=0.
  - No mdu_done is produced.
- Register 0 never causes a load-use stall.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- With the macro defined:
  - stall_cnt is a PERF_W-bit counter.
  - It increments on every cycle with PC_Wr==0 and wraps modulo 2^PERF_W.
  - It is cleared only by reset.
- Without the macro: stall_cnt is tied to 0 and no counter flops are synthesized.

Decomposition:
- Shared package / ctrl_encode_def.v additions:
  - state encodings: `HZ_RUN, `HZ_MDU_BUSY;
  - `DMRd_NOP, reused as is.
- One natural sub-module: mdu_timer.
  - Loadable down-counter with load, cnt, and a done pulse.
  - Instantiated once.
- Hazard compares stay inline.

Test Plan:
- Load-use: IDEX_DMRd=LW, IDEX_rd=8, IFID_rs=8, IFID_use_rs=1 -> exactly 1 cycle with PC_Wr=0, IFID_Wr=0, IDEX_flush=1, then normal flow.
- Load to $0: IDEX_DMRd=LW, IDEX_rd=0, IFID_rs=0 -> no stall, all enables 1.
- MDU issue with MDU_LAT=4: IFID_mdu=1 in RUN -> mdu_start pulse, mdu_busy for 3 cycles, mdu_done on the third. An mfhi presented in ID during busy stalls until the cycle after mdu_done.
- Branch over stall: EX_br_taken=1 with lu_haz=1 -> IFID_flush=1, IDEX_flush=1, PC_Wr=1. Branch during MDU_BUSY -> mdu_done still arrives on schedule.
- Reset abort: deassert rstn (drive low) 2 cycles into MDU_BUSY -> mdu_busy=0 immediately, no mdu_done, PC_Wr=1 after release.
- HAZARD_PERF_CNT_EN build: 1 load-use stall plus 3 HI/LO stall cycles -> stall_cnt=4. Without the macro -> stall_cnt=0.
